// File: rtl/trigger_pulse_driver.sv
// trigger_pulse_driver: fixed-width, holdoff-protected trigger pulse generator
// for the OBUFDS trigger lines. It keeps saturating counts of issued and
// dropped requests.
// Optional build macro TRIGGER_PERIODIC_EN adds an internal periodic
// self-test source and the period_i port.
module trigger_pulse_driver #(
  parameter int PULSE_BITS   = 4,
  parameter int HOLDOFF_BITS = 8,
  parameter int COUNT_BITS   = 16,
  parameter int PERIOD_BITS  = 24
) (
  input  logic                    fast_clk_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic                    trig_req_i,
  input  logic [PULSE_BITS-1:0]   pulse_len_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic                    count_clr_i,
`ifdef TRIGGER_PERIODIC_EN
  input  logic [PERIOD_BITS-1:0]  period_i,
`endif
  output logic                    trig_o,
  output logic                    busy_o,
  output logic [COUNT_BITS-1:0]   issued_o,
  output logic [COUNT_BITS-1:0]   dropped_o
);

  // One down-counter serves both the pulse and the holdoff phase.
  localparam int CNT_W = (PULSE_BITS > HOLDOFF_BITS) ? PULSE_BITS : HOLDOFF_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
  logic                    trig_q;
  logic                    req;
  logic                    accept;
  logic                    drop;
  logic [CNT_W-1:0]        len_m1;

`ifdef TRIGGER_PERIODIC_EN
  logic [PERIOD_BITS-1:0] per_cnt_q;
  logic                   per_run;
  logic                   per_tick;

  // Counting runs only while enabled with a nonzero period. If the period
  // shrinks below the current count, the count runs on to wrap at all-ones.
  assign per_run  = enable_i && (period_i != '0);
  assign per_tick = per_run && (per_cnt_q == period_i - 1'b1);

  // Free-running period counter; held at zero when idle.
  always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      per_cnt_q <= '0;
    else if (!per_run) per_cnt_q <= '0;
    else if (per_tick) per_cnt_q <= '0;
    else               per_cnt_q <= per_cnt_q + 1'b1;
  end

  // A coincident external request and internal tick merge into one request.
  assign req = trig_req_i | per_tick;
`else
  assign req = trig_req_i;
`endif

  // A pulse length of 0 behaves as 1. The counter holds the remaining length minus 1.
  assign len_m1 = (pulse_len_i == '0) ? '0 : (CNT_W'(pulse_len_i) - 1'b1);

  // Next-state logic. Settings are captured only at acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    accept  = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i && req) begin
          accept  = 1'b1;
          state_d = PULSE;
          cnt_d   = len_m1;
          hold_d  = holdoff_i;
        end
      end
      PULSE: begin
        drop = enable_i && req;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (hold_q != '0) begin
          state_d = HOLDOFF;
          cnt_d   = CNT_W'(hold_q) - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HOLDOFF: begin
        drop = enable_i && req;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and the output flop. trig_o comes straight from a register.
  always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      trig_q  <= (state_d == PULSE);
    end
  end

  // Saturating issued counter. A clear beats a simultaneous increment.
  always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                     issued_o <= '0;
    else if (count_clr_i)             issued_o <= '0;
    else if (accept && !(&issued_o))  issued_o <= issued_o + 1'b1;
  end

  // Saturating dropped counter. A clear beats a simultaneous increment.
  always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                     dropped_o <= '0;
    else if (count_clr_i)             dropped_o <= '0;
    else if (drop && !(&dropped_o))   dropped_o <= dropped_o + 1'b1;
  end

  assign trig_o = trig_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_trigger_pulse_driver.sv
// Directed bench for trigger_pulse_driver. It uses a vector table plus
// hand-written sequences for saturation, clear, async reset and the
// periodic source (built with TRIGGER_PERIODIC_EN).
module tb_trigger_pulse_driver;
  localparam int PB = 4, HB = 8, CB = 4, PERB = 24;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable, trig_req, count_clr;
  logic [PB-1:0]   pulse_len;
  logic [HB-1:0]   holdoff;
  logic            trig, busy;
  logic [CB-1:0]   issued, dropped;
`ifdef TRIGGER_PERIODIC_EN
  logic [PERB-1:0] period;
`endif

  int checks = 0;
  int errors = 0;

  trigger_pulse_driver #(
    .PULSE_BITS(PB), .HOLDOFF_BITS(HB), .COUNT_BITS(CB), .PERIOD_BITS(PERB)
  ) dut (
    .fast_clk_i (clk),
    .rst_n_i    (rst_n),
    .enable_i   (enable),
    .trig_req_i (trig_req),
    .pulse_len_i(pulse_len),
    .holdoff_i  (holdoff),
    .count_clr_i(count_clr),
`ifdef TRIGGER_PERIODIC_EN
    .period_i   (period),
`endif
    .trig_o     (trig),
    .busy_o     (busy),
    .issued_o   (issued),
    .dropped_o  (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic req, en, clr;
    int   len, hold;
    logic trig, busy;
    int   iss, drp;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // L=3 H=2 single request
    vq.push_back('{1,1,0,3,2, 1,1, 1,0});
    vq.push_back('{0,1,0,3,2, 1,1, 1,0});
    vq.push_back('{0,1,0,3,2, 1,1, 1,0});
    vq.push_back('{0,1,0,3,2, 0,1, 1,0});
    vq.push_back('{0,1,0,3,2, 0,1, 1,0});
    vq.push_back('{0,1,0,3,2, 0,0, 1,0});
    vq.push_back('{0,1,1,3,2, 0,0, 0,0});
    // L=0 H=0, request held 6 cycles
    vq.push_back('{1,1,0,0,0, 1,1, 1,0});
    vq.push_back('{1,1,0,0,0, 0,0, 1,1});
    vq.push_back('{1,1,0,0,0, 1,1, 2,1});
    vq.push_back('{1,1,0,0,0, 0,0, 2,2});
    vq.push_back('{1,1,0,0,0, 1,1, 3,2});
    vq.push_back('{1,1,0,0,0, 0,0, 3,3});
    vq.push_back('{0,1,1,0,0, 0,0, 0,0});
    // L=4 H=4, requests at accept+2 and accept+6 are dropped
    vq.push_back('{1,1,0,4,4, 1,1, 1,0});
    vq.push_back('{0,1,0,4,4, 1,1, 1,0});
    vq.push_back('{1,1,0,4,4, 1,1, 1,1});
    vq.push_back('{0,1,0,4,4, 1,1, 1,1});
    vq.push_back('{0,1,0,4,4, 0,1, 1,1});
    vq.push_back('{0,1,0,4,4, 0,1, 1,1});
    vq.push_back('{1,1,0,4,4, 0,1, 1,2});
    vq.push_back('{0,1,0,4,4, 0,1, 1,2});
    vq.push_back('{0,1,0,4,4, 0,0, 1,2});
    vq.push_back('{0,1,1,4,4, 0,0, 0,0});
    // enable low: requests ignored
    for (int i = 0; i < 5; i++) vq.push_back('{1,0,0,4,4, 0,0, 0,0});
    // L=8 H=0, enable dropped mid-pulse, full pulse still emitted
    vq.push_back('{1,1,0,8,0, 1,1, 1,0});
    vq.push_back('{0,0,0,8,0, 1,1, 1,0});
    vq.push_back('{0,0,0,8,0, 1,1, 1,0});
    vq.push_back('{1,0,0,8,0, 1,1, 1,0});
    for (int i = 0; i < 4; i++) vq.push_back('{0,0,0,8,0, 1,1, 1,0});
    vq.push_back('{0,0,0,8,0, 0,0, 1,0});
    vq.push_back('{0,0,1,8,0, 0,0, 0,0});

    rst_n = 1'b0; enable = 1'b0; trig_req = 1'b0; count_clr = 1'b0;
    pulse_len = '0; holdoff = '0;
`ifdef TRIGGER_PERIODIC_EN
    period = '0;
`endif
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("reset trig", trig, 0);
    chk("reset busy", busy, 0);
    chk("reset issued", issued, 0);
    chk("reset dropped", dropped, 0);

    foreach (vq[i]) begin
      trig_req  = vq[i].req;
      enable    = vq[i].en;
      count_clr = vq[i].clr;
      pulse_len = PB'(vq[i].len);
      holdoff   = HB'(vq[i].hold);
      step();
      chk($sformatf("v%0d trig", i), trig, vq[i].trig);
      chk($sformatf("v%0d busy", i), busy, vq[i].busy);
      chk($sformatf("v%0d issued", i), issued, vq[i].iss);
      chk($sformatf("v%0d dropped", i), dropped, vq[i].drp);
    end
    count_clr = 1'b0;

    // Saturation: 20 accepts with a 4-bit counter
    enable = 1'b1; pulse_len = PB'(1); holdoff = '0;
    for (int i = 0; i < 20; i++) begin
      trig_req = 1'b1; step();
      trig_req = 1'b0; step();
    end
    chk("sat issued", issued, 15);
    chk("sat dropped", dropped, 0);

    // Clear coincident with an accept: the clear wins
    trig_req = 1'b1; count_clr = 1'b1; step();
    chk("clr+accept issued", issued, 0);
    chk("clr+accept trig", trig, 1);
    trig_req = 1'b0; count_clr = 1'b0; step();
    chk("post clr issued", issued, 0);

    // Async reset mid-pulse drops trig_o immediately
    pulse_len = PB'(8);
    trig_req = 1'b1; step();
    trig_req = 1'b0; step(); step();
    chk("pre-reset trig", trig, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async reset trig", trig, 0);
    chk("async reset busy", busy, 0);
    chk("async reset issued", issued, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("after reset idle busy", busy, 0);
    trig_req = 1'b1; step();
    chk("after reset accept trig", trig, 1);
    chk("after reset accept issued", issued, 1);
    trig_req = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("after reset pulse done", busy, 0);

`ifdef TRIGGER_PERIODIC_EN
    // Periodic source, period 10, L=2 H=0; external request on the tick at edge 30
    pulse_len = PB'(2); holdoff = '0;
    count_clr = 1'b1; step();
    count_clr = 1'b0;
    period = PERB'(10);
    for (int k = 1; k <= 40; k++) begin
      trig_req = (k == 30);
      step();
      chk($sformatf("per k%0d trig", k), trig,
          ((k >= 10) && ((k % 10 == 0) || (k % 10 == 1))) ? 1 : 0);
    end
    trig_req = 1'b0;
    chk("per issued", issued, 4);
    chk("per dropped", dropped, 0);
    period = '0;
    step(); step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
